// File: rtl/hall_speed_detector_pkg.sv
// hall_speed_detector_pkg: default parameters and saturating-increment helper for the hall speed detector
package hall_speed_detector_pkg;
    localparam int unsigned DEF_WINDOW_CYCLES = 10_000_000;
    localparam int unsigned DEF_FILTER_CYCLES = 16;
    localparam int unsigned DEF_CNT_W = 16;
    localparam int unsigned DEF_PERIOD_W = 32;

    function automatic logic [63:0] sat_inc(input logic [63:0] v, input int unsigned w);
        logic [63:0] max_v;
        max_v = (w >= 64) ? '1 : (64'd1 << w) - 64'd1;
        return (v >= max_v) ? max_v : v + 64'd1;
    endfunction
endpackage

// File: rtl/hall_glitch_filter.sv
// hall_glitch_filter: two-flop synchronizer plus stability filter on a raw hall input
module hall_glitch_filter
    import hall_speed_detector_pkg::*;
#(
    parameter int unsigned FILTER_CYCLES = DEF_FILTER_CYCLES
) (
    input  logic clk,
    input  logic resetn,
    input  logic din,
    output logic dout
);
    localparam int unsigned FC_W = $clog2(FILTER_CYCLES);

    logic s1_q, s2_q, filt_q, filt_d;
    logic [FC_W-1:0] fc_q, fc_d;

    always_comb begin
        filt_d = filt_q;
        fc_d = '0;
        if (s2_q != filt_q) begin
            if (fc_q == FC_W'(FILTER_CYCLES - 1)) filt_d = ~filt_q;
            else fc_d = fc_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            filt_q <= 1'b0;
            fc_q <= '0;
        end else begin
            s1_q <= din;
            s2_q <= s1_q;
            filt_q <= filt_d;
            fc_q <= fc_d;
        end
    end

    assign dout = filt_q;
endmodule

// File: rtl/hall_speed_detector.sv
// hall_speed_detector: per-window rising-edge count and edge-to-edge period of a filtered hall input
module hall_speed_detector
    import hall_speed_detector_pkg::*;
#(
    parameter int unsigned WINDOW_CYCLES = DEF_WINDOW_CYCLES,
    parameter int unsigned FILTER_CYCLES = DEF_FILTER_CYCLES,
    parameter int unsigned CNT_W = DEF_CNT_W,
    parameter int unsigned PERIOD_W = DEF_PERIOD_W
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                sa,
    input  logic                clear,
    output logic [CNT_W-1:0]    edge_count,
    output logic [PERIOD_W-1:0] period,
    output logic                count_valid,
    output logic                period_valid,
    output logic                stalled
);
    localparam int unsigned WC_W = $clog2(WINDOW_CYCLES);
    localparam logic [PERIOD_W-1:0] PC_MAX = '1;

    logic filt, filt_prev_q, rise, term;
    logic [WC_W-1:0] wc_q, wc_d;
    logic [CNT_W-1:0] acc_q, acc_d, acc_inc, edge_count_q, edge_count_d;
    logic [PERIOD_W-1:0] pc_q, pc_d, pc_inc, period_q, period_d;
    logic armed_q, armed_d, stalled_q, stalled_d;
    logic count_valid_q, count_valid_d, period_valid_q, period_valid_d;

    hall_glitch_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_filter (
        .clk(clk),
        .resetn(resetn),
        .din(sa),
        .dout(filt)
    );

    assign rise = filt & ~filt_prev_q;
    assign term = wc_q == WC_W'(WINDOW_CYCLES - 1);
    assign acc_inc = rise ? CNT_W'(sat_inc(64'(acc_q), CNT_W)) : acc_q;
    assign pc_inc = PERIOD_W'(sat_inc(64'(pc_q), PERIOD_W));

    always_comb begin
        wc_d = term ? '0 : wc_q + 1'b1;
        acc_d = term ? '0 : acc_inc;
        edge_count_d = term ? acc_inc : edge_count_q;
        count_valid_d = term;
        pc_d = rise ? '0 : pc_inc;
        armed_d = armed_q | rise;
        stalled_d = rise ? 1'b0 : (stalled_q | (pc_inc == PC_MAX));
        // a rise ending a saturated interval only re-arms; its length is unknown
        period_valid_d = rise & armed_q & ~stalled_q;
        period_d = period_valid_d ? pc_inc : period_q;
        if (clear) begin
            wc_d = '0;
            acc_d = '0;
            pc_d = '0;
            armed_d = 1'b0;
            stalled_d = 1'b0;
            count_valid_d = 1'b0;
            period_valid_d = 1'b0;
            edge_count_d = edge_count_q;
            period_d = period_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            filt_prev_q <= 1'b0;
            wc_q <= '0;
            acc_q <= '0;
            pc_q <= '0;
            armed_q <= 1'b0;
            stalled_q <= 1'b0;
            edge_count_q <= '0;
            period_q <= '0;
            count_valid_q <= 1'b0;
            period_valid_q <= 1'b0;
        end else begin
            filt_prev_q <= filt;
            wc_q <= wc_d;
            acc_q <= acc_d;
            pc_q <= pc_d;
            armed_q <= armed_d;
            stalled_q <= stalled_d;
            edge_count_q <= edge_count_d;
            period_q <= period_d;
            count_valid_q <= count_valid_d;
            period_valid_q <= period_valid_d;
        end
    end

    assign edge_count = edge_count_q;
    assign period = period_q;
    assign count_valid = count_valid_q;
    assign period_valid = period_valid_q;
    assign stalled = stalled_q;
endmodule

// File: tb/tb_hall_speed_detector.sv
// tb_hall_speed_detector: directed checks of counting, filtering, saturation, stall, clear and reset
module tb_hall_speed_detector;
    logic clk = 1'b0, resetn = 1'b0, sa = 1'b0, clear = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] edge_count, edge_count_p;
    logic [3:0]  edge_count_c;
    logic [31:0] period, period_c;
    logic [7:0]  period_p;
    logic count_valid, period_valid, stalled;
    logic count_valid_c, period_valid_c, stalled_c;
    logic count_valid_p, period_valid_p, stalled_p;

    hall_speed_detector #(.WINDOW_CYCLES(1000), .FILTER_CYCLES(4), .CNT_W(16), .PERIOD_W(32)) dut (
        .clk(clk), .resetn(resetn), .sa(sa), .clear(clear),
        .edge_count(edge_count), .period(period), .count_valid(count_valid),
        .period_valid(period_valid), .stalled(stalled)
    );
    hall_speed_detector #(.WINDOW_CYCLES(1000), .FILTER_CYCLES(4), .CNT_W(4), .PERIOD_W(32)) dut_c (
        .clk(clk), .resetn(resetn), .sa(sa), .clear(clear),
        .edge_count(edge_count_c), .period(period_c), .count_valid(count_valid_c),
        .period_valid(period_valid_c), .stalled(stalled_c)
    );
    hall_speed_detector #(.WINDOW_CYCLES(1000), .FILTER_CYCLES(4), .CNT_W(16), .PERIOD_W(8)) dut_p (
        .clk(clk), .resetn(resetn), .sa(sa), .clear(clear),
        .edge_count(edge_count_p), .period(period_p), .count_valid(count_valid_p),
        .period_valid(period_valid_p), .stalled(stalled_p)
    );

    int checks = 0, passed = 0, cyc = 0, c0 = 0;
    int cv_n, pv_n, last_ec, min_ec, max_ec, last_cv_cyc, first_pv_cyc, last_ecc, pvp_n, stall_cyc;

    task automatic clr_obs;
        cv_n = 0; pv_n = 0; last_ec = -1; min_ec = 1 << 30; max_ec = -1;
        last_cv_cyc = -1; first_pv_cyc = -1; last_ecc = -1; pvp_n = 0; stall_cyc = -1;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
        cyc++;
        if (count_valid) begin
            cv_n++;
            last_ec = int'(edge_count);
            last_cv_cyc = cyc;
            if (last_ec < min_ec) min_ec = last_ec;
            if (last_ec > max_ec) max_ec = last_ec;
        end
        if (period_valid) begin
            pv_n++;
            if (first_pv_cyc < 0) first_pv_cyc = cyc;
        end
        if (count_valid_c) last_ecc = int'(edge_count_c);
        if (period_valid_p) pvp_n++;
        if (stalled_p && stall_cyc < 0) stall_cyc = cyc;
    endtask

    task automatic do_reset;
        resetn = 1'b0; sa = 1'b0; clear = 1'b0;
        repeat (4) tick();
        resetn = 1'b1;
        clr_obs();
        c0 = cyc;
    endtask

    task automatic test_reset;
        resetn = 1'b0;
        for (int i = 0; i < 6; i++) begin sa = i[0]; tick(); end
        sa = 1'b0;
        checks++; if (edge_count !== 16'd0) $display("FAIL reset_edge_count: got %0d expected 0", edge_count); else passed++;
        checks++; if (period !== 32'd0) $display("FAIL reset_period: got %0d expected 0", period); else passed++;
        checks++; if ({count_valid, period_valid, stalled} !== 3'b000) $display("FAIL reset_flags: got %b expected 000", {count_valid, period_valid, stalled}); else passed++;
    endtask

    task automatic test_square;
        do_reset();
        for (int i = 0; i < 3500; i++) begin sa = (i % 100) < 50; tick(); end
        checks++; if (first_pv_cyc - c0 !== 107) $display("FAIL sq_first_pv: got cycle %0d expected 107", first_pv_cyc - c0); else passed++;
        checks++; if (pv_n !== 34) $display("FAIL sq_pv_count: got %0d expected 34", pv_n); else passed++;
        checks++; if (period !== 32'd100) $display("FAIL sq_period: got %0d expected 100", period); else passed++;
        checks++; if (cv_n !== 3) $display("FAIL sq_cv_count: got %0d expected 3", cv_n); else passed++;
        checks++; if (last_cv_cyc - c0 !== 3000) $display("FAIL sq_cv_timing: got cycle %0d expected 3000", last_cv_cyc - c0); else passed++;
        checks++; if (min_ec !== 10 || max_ec !== 10) $display("FAIL sq_edge_count: got min %0d max %0d expected 10", min_ec, max_ec); else passed++;
    endtask

    task automatic test_glitch;
        do_reset();
        for (int i = 0; i < 1005; i++) begin sa = i >= 10 && i < 13; tick(); end
        checks++; if (cv_n !== 1 || last_ec !== 0) $display("FAIL glitch3_count: got cv %0d ec %0d expected cv 1 ec 0", cv_n, last_ec); else passed++;
        for (int i = 0; i < 1000; i++) begin sa = i >= 10 && i < 14; tick(); end
        checks++; if (cv_n !== 2 || last_ec !== 1) $display("FAIL pulse4_count: got cv %0d ec %0d expected cv 2 ec 1", cv_n, last_ec); else passed++;
        checks++; if (pv_n !== 0) $display("FAIL glitch_pv: got %0d expected 0", pv_n); else passed++;
    endtask

    task automatic test_saturate_count;
        do_reset();
        for (int i = 0; i < 1005; i++) begin sa = (i % 20) < 10; tick(); end
        checks++; if (last_ecc !== 15) $display("FAIL cnt_sat: got %0d expected 15", last_ecc); else passed++;
        checks++; if (last_ec !== 50) $display("FAIL cnt_wide: got %0d expected 50", last_ec); else passed++;
        checks++; if (period !== 32'd20) $display("FAIL period_20: got %0d expected 20", period); else passed++;
    endtask

    task automatic test_stall;
        do_reset();
        for (int i = 0; i < 300; i++) begin sa = i < 10; tick(); end
        checks++; if (stall_cyc - c0 !== 262) $display("FAIL stall_time: got cycle %0d expected 262", stall_cyc - c0); else passed++;
        checks++; if (stalled_p !== 1'b1) $display("FAIL stall_level: got %b expected 1", stalled_p); else passed++;
        checks++; if (stalled !== 1'b0) $display("FAIL stall_wide: got %b expected 0", stalled); else passed++;
        for (int i = 0; i < 110; i++) begin sa = i < 10; tick(); end
        checks++; if (stalled_p !== 1'b0) $display("FAIL stall_clear: got %b expected 0", stalled_p); else passed++;
        checks++; if (pvp_n !== 0) $display("FAIL stall_no_pv: got %0d expected 0", pvp_n); else passed++;
        for (int i = 0; i < 20; i++) begin sa = i < 10; tick(); end
        checks++; if (pvp_n !== 1 || period_p !== 8'd110) $display("FAIL stall_next_period: got pv %0d period %0d expected pv 1 period 110", pvp_n, period_p); else passed++;
    endtask

    task automatic test_clear_terminal;
        do_reset();
        for (int i = 0; i < 3005; i++) begin
            sa = (i % 100) < 50;
            clear = i == 1999;
            tick();
            if (i == 1999) begin
                checks++; if (count_valid !== 1'b0) $display("FAIL clr_term_cv: got %b expected 0", count_valid); else passed++;
                checks++; if (edge_count !== 16'd10) $display("FAIL clr_term_ec: got %0d expected 10", edge_count); else passed++;
            end
            if (i == 2500) begin
                checks++; if (edge_count !== 16'd10 || period !== 32'd100) $display("FAIL clr_hold: got ec %0d period %0d expected 10 100", edge_count, period); else passed++;
            end
        end
        clear = 1'b0;
        checks++; if (cv_n !== 2 || last_cv_cyc - c0 !== 3000) $display("FAIL clr_next_cv: got cv %0d at %0d expected 2 at 3000", cv_n, last_cv_cyc - c0); else passed++;
        checks++; if (pv_n !== 28) $display("FAIL clr_rearm: got pv %0d expected 28", pv_n); else passed++;
        checks++; if (last_ec !== 10) $display("FAIL clr_window_ec: got %0d expected 10", last_ec); else passed++;
    endtask

    task automatic test_clear_rise;
        do_reset();
        for (int i = 0; i < 1020; i++) begin sa = i >= 10; clear = i == 16; tick(); end
        clear = 1'b0;
        checks++; if (cv_n !== 1 || last_cv_cyc - c0 !== 1017) $display("FAIL clr_rise_cv: got cv %0d at %0d expected 1 at 1017", cv_n, last_cv_cyc - c0); else passed++;
        checks++; if (last_ec !== 0) $display("FAIL clr_rise_dropped: got %0d expected 0", last_ec); else passed++;
    endtask

    task automatic test_mid_reset;
        do_reset();
        for (int i = 0; i < 1500; i++) begin sa = (i % 100) < 50; tick(); end
        checks++; if (edge_count !== 16'd10) $display("FAIL pre_reset_ec: got %0d expected 10", edge_count); else passed++;
        resetn = 1'b0;
        tick(); tick();
        checks++; if (edge_count !== 16'd0 || period !== 32'd0) $display("FAIL mid_reset_vals: got ec %0d period %0d expected 0 0", edge_count, period); else passed++;
        checks++; if ({count_valid, period_valid, stalled} !== 3'b000) $display("FAIL mid_reset_flags: got %b expected 000", {count_valid, period_valid, stalled}); else passed++;
        resetn = 1'b1;
        clr_obs();
        for (int i = 0; i < 1005; i++) begin sa = i < 300 && (i % 100) < 50; tick(); end
        checks++; if (cv_n !== 1 || last_ec !== 3) $display("FAIL post_reset_ec: got cv %0d ec %0d expected 1 3", cv_n, last_ec); else passed++;
        checks++; if (pv_n !== 2 || period !== 32'd100) $display("FAIL post_reset_period: got pv %0d period %0d expected 2 100", pv_n, period); else passed++;
    endtask

    initial begin
        clr_obs();
        test_reset();
        test_square();
        test_glitch();
        test_saturate_count();
        test_stall();
        test_clear_terminal();
        test_clear_rise();
        test_mid_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
